// File: rtl/mem_bus_arb.sv
// Round-robin arbiter folding the L1i refill bus and the L1d refill/writeback bus onto one memory port.
// One transaction at a time: strobe 1 cycle after request, dv 1 cycle after m_dv, IDLE again the cycle after dv.
module mem_bus_arb #(
    parameter int LINE_W = 1024,
    parameter int ADDR_W = 64,
    parameter int OFFS_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_dv,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    output logic              m_rd,
    output logic              m_wr,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_dv,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic RR_I = 1'b0;
    localparam logic RR_D = 1'b1;

    state_t state;
    state_t state_nxt;
    logic   rr_last;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

    // On a tie the side that was not served last wins.
    always_comb begin
        d_req     = d_rd | d_wr;
        grant_d   = d_req & (~i_rd | (rr_last == RR_I));
        grant_i   = i_rd & (~d_req | (rr_last == RR_D));
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)
                    state_nxt = BUSY_D;
                else if (grant_i)
                    state_nxt = BUSY_I;
            end
            BUSY_I,
            BUSY_D: begin
                if (m_dv)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last <= RR_I;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
            owner   <= 2'b00;
            i_data  <= '0;
            d_rdata <= '0;
            i_dv    <= 1'b0;
            d_dv    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        m_addr  <= {d_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
                        m_wdata <= d_wdata;
                        // A simultaneous rd+wr is a writeback.
                        m_wr    <= d_wr;
                        m_rd    <= ~d_wr;
                        owner   <= 2'b10;
                        rr_last <= RR_D;
                    end else if (grant_i) begin
                        m_addr  <= {i_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
                        m_rd    <= 1'b1;
                        m_wr    <= 1'b0;
                        owner   <= 2'b01;
                        rr_last <= RR_I;
                    end
                end
                BUSY_I: begin
                    if (m_dv) begin
                        m_rd   <= 1'b0;
                        i_data <= m_rdata;
                        i_dv   <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (m_dv) begin
                        m_rd <= 1'b0;
                        m_wr <= 1'b0;
                        if (!m_wr)
                            d_rdata <= m_rdata;
                        d_dv <= 1'b1;
                    end
                end
                DONE: begin
                    i_dv  <= 1'b0;
                    d_dv  <= 1'b0;
                    owner <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb: reset, single read, contention ordering, writes, and reset mid-transaction.
module tb_mem_bus_arb;

    localparam int LINE_W = 1024;
    localparam int ADDR_W = 64;
    localparam int OFFS_W = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rd;
    logic [LINE_W-1:0] i_data;
    logic              i_dv;
    logic [ADDR_W-1:0] d_addr;
    logic              d_rd;
    logic              d_wr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_dv;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic              m_rd;
    logic              m_wr;
    logic [LINE_W-1:0] m_rdata;
    logic              m_dv;
    logic [1:0]        owner;

    int vectors = 0;
    int miscompares = 0;

    logic [LINE_W-1:0] pat_i;
    logic [LINE_W-1:0] pat_d;
    logic [LINE_W-1:0] pat_i2;
    logic [LINE_W-1:0] pat_wb;
    logic [LINE_W-1:0] pat_junk;

    mem_bus_arb #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFS_W(OFFS_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_dv(d_dv),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
        .m_rdata(m_rdata), .m_dv(m_dv), .owner(owner)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled and inputs driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (low 64 bits shown)", tag, obs[63:0], exp[63:0]);
        end
    endtask

    initial begin
        pat_i    = {32{32'hA5A5_0001}};
        pat_d    = {32{32'h0D0D_0002}};
        pat_i2   = {32{32'h1111_0003}};
        pat_wb   = {32{32'hDEAD_BEEF}};
        pat_junk = {32{32'hFFFF_FFFF}};

        // Reset with both sides requesting.
        rst_n = 1'b0; i_addr = '0; i_rd = 1'b1; d_addr = '0; d_rd = 1'b0; d_wr = 1'b1;
        d_wdata = '0; m_rdata = '0; m_dv = 1'b0;
        tick(); tick();
        chk("rst_i_dv", i_dv, 0);
        chk("rst_d_dv", d_dv, 0);
        chk("rst_m_rd", m_rd, 0);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_owner", owner, 0);
        chk("rst_i_data", i_data, 0);
        chk("rst_d_rdata", d_rdata, 0);

        // First tie after reset goes to D.
        rst_n = 1'b1;
        tick();
        chk("first_m_wr", m_wr, 1);
        chk("first_m_rd", m_rd, 0);
        chk("first_owner", owner, 2'b10);
        m_dv = 1'b1;
        tick();
        chk("first_d_dv", d_dv, 1);
        chk("first_i_dv", i_dv, 0);
        chk("first_m_wr_off", m_wr, 0);
        m_dv = 1'b0; i_rd = 1'b0; d_wr = 1'b0;
        tick();
        chk("first_idle_owner", owner, 0);
        chk("first_d_dv_off", d_dv, 0);

        // Single I read with three cycles of memory latency.
        i_addr = 64'h0000_0000_8000_0045; i_rd = 1'b1;
        tick();
        chk("iread_m_rd", m_rd, 1);
        chk("iread_m_addr", m_addr, 64'h0000_0000_8000_0000);
        chk("iread_owner", owner, 2'b01);
        tick(); tick(); tick();
        chk("iread_wait_i_dv", i_dv, 0);
        chk("iread_wait_m_rd", m_rd, 1);
        m_dv = 1'b1; m_rdata = pat_i;
        tick();
        chk("iread_i_dv", i_dv, 1);
        chk("iread_i_data", i_data, pat_i);
        chk("iread_m_rd_off", m_rd, 0);
        chk("iread_d_dv", d_dv, 0);
        m_dv = 1'b0; i_rd = 1'b0;
        tick();
        chk("iread_i_dv_pulse", i_dv, 0);
        chk("iread_owner_off", owner, 0);

        // Contention: D (not last) first, then I, then D again on a fresh tie.
        i_addr = 64'h4000; i_rd = 1'b1; d_addr = 64'h3000; d_rd = 1'b1;
        tick();
        chk("cont1_owner", owner, 2'b10);
        chk("cont1_m_addr", m_addr, 64'h3000);
        m_dv = 1'b1; m_rdata = pat_d;
        tick();
        chk("cont1_d_dv", d_dv, 1);
        chk("cont1_d_rdata", d_rdata, pat_d);
        chk("cont1_i_data_hold", i_data, pat_i);
        m_dv = 1'b0; d_rd = 1'b0;
        tick();
        chk("cont_gap_m_rd", m_rd, 0);
        tick();
        chk("cont2_m_rd", m_rd, 1);
        chk("cont2_owner", owner, 2'b01);
        chk("cont2_m_addr", m_addr, 64'h4000);
        m_dv = 1'b1; m_rdata = pat_i2;
        tick();
        chk("cont2_i_dv", i_dv, 1);
        chk("cont2_i_data", i_data, pat_i2);
        chk("cont2_d_rdata_hold", d_rdata, pat_d);
        m_dv = 1'b0; i_rd = 1'b0;
        tick();
        i_rd = 1'b1; d_rd = 1'b1;
        tick();
        chk("cont3_owner", owner, 2'b10);
        m_dv = 1'b1; m_rdata = pat_d;
        tick();
        chk("cont3_d_dv", d_dv, 1);
        m_dv = 1'b0; i_rd = 1'b0; d_rd = 1'b0;
        tick();

        // D writeback: d_rdata must keep its last read value.
        d_wr = 1'b1; d_addr = 64'h1000; d_wdata = pat_wb;
        tick();
        chk("dwr_m_wr", m_wr, 1);
        chk("dwr_m_rd", m_rd, 0);
        chk("dwr_m_wdata", m_wdata, pat_wb);
        chk("dwr_m_addr", m_addr, 64'h1000);
        d_wdata = pat_junk;
        tick();
        chk("dwr_m_wdata_hold", m_wdata, pat_wb);
        m_dv = 1'b1; m_rdata = pat_junk;
        tick();
        chk("dwr_d_dv", d_dv, 1);
        chk("dwr_d_rdata_hold", d_rdata, pat_d);
        chk("dwr_m_wr_off", m_wr, 0);
        m_dv = 1'b0; d_wr = 1'b0;
        tick();

        // rd+wr together is a write; address changes mid-BUSY are ignored.
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 64'h1000;
        tick();
        chk("rdwr_m_wr", m_wr, 1);
        chk("rdwr_m_rd", m_rd, 0);
        d_addr = 64'h2000;
        tick();
        chk("rdwr_m_addr_hold", m_addr, 64'h1000);
        m_dv = 1'b1;
        tick();
        chk("rdwr_d_dv", d_dv, 1);
        chk("rdwr_d_rdata_hold", d_rdata, pat_d);
        m_dv = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        tick();

        // Reset in BUSY_I abandons the transaction; a later m_dv is ignored.
        i_addr = 64'h5000; i_rd = 1'b1;
        tick();
        chk("rstb_m_rd", m_rd, 1);
        rst_n = 1'b0;
        tick();
        chk("rstb_m_rd_off", m_rd, 0);
        chk("rstb_owner", owner, 0);
        chk("rstb_i_data", i_data, 0);
        rst_n = 1'b1; i_rd = 1'b0; m_dv = 1'b1; m_rdata = pat_i;
        tick();
        chk("rstb_i_dv", i_dv, 0);
        chk("rstb_i_data_after", i_data, 0);
        chk("rstb_m_rd_after", m_rd, 0);
        m_dv = 1'b0;
        tick();
        chk("rstb_i_dv_later", i_dv, 0);
        chk("rstb_owner_later", owner, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
